icb2apb_bridge_n: RTL and testbench

Parametrised ICB-to-APB bridge. One ICB slave port fans out to NUM_APB APB4 master channels, generalising the fixed four-channel bridge. Adds base/region address decode with decode-error response, APB4 PSTRB from the ICB write mask, PSLVERR forwarding, and a programmable PREADY timeout. Sits between the ICB interconnect and the peripheral APB segments; one outstanding transfer.

---
 rtl/icb2apb_bridge_n.sv | 185 ++++++++++++++++++
 tb/tb_icb2apb_bridge_n.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icb2apb_bridge_n.sv
// ICB slave to NUM_APB-channel APB4 master bridge with window decode, PSTRB,
// PSLVERR forwarding and an ACCESS-phase PREADY timeout. One transfer in flight.
module icb2apb_bridge_n #(
  parameter int              NUM_APB   = 4,
  parameter int              AW        = 32,
  parameter int              DW        = 32,
  parameter int              SEL_LSB   = 12,
  parameter logic [AW-1:0]   BASE_ADDR = 32'h1000_0000,
  parameter int              TIMEOUT   = 256,
  parameter int              TOW       = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  icb_cmd_valid,
  output logic                  icb_cmd_ready,
  input  logic [AW-1:0]         icb_cmd_addr,
  input  logic                  icb_cmd_read,
  input  logic [DW-1:0]         icb_cmd_wdata,
  input  logic [DW/8-1:0]       icb_cmd_wmask,
  output logic                  icb_rsp_valid,
  input  logic                  icb_rsp_ready,
  output logic [DW-1:0]         icb_rsp_rdata,
  output logic                  icb_rsp_err,
  output logic [AW-1:0]         apb_paddr,
  output logic                  apb_pwrite,
  output logic [DW-1:0]         apb_pwdata,
  output logic [DW/8-1:0]       apb_pstrb,
  output logic [2:0]            apb_pprot,
  output logic                  apb_penable,
  output logic [NUM_APB-1:0]    apb_psel,
  input  logic [NUM_APB*DW-1:0] apb_prdata,
  input  logic [NUM_APB-1:0]    apb_pready,
  input  logic [NUM_APB-1:0]    apb_pslverr,
  output logic [1:0]            dbg_state_o
);

  localparam int SELW = (NUM_APB > 1) ? $clog2(NUM_APB) : 1;
  localparam int MW   = DW / 8;
  localparam int TOP  = SEL_LSB + SELW;
  localparam logic [TOW:0]  TMO_LIM = TIMEOUT[TOW:0];
  localparam logic [SELW:0] NUM_LIM = NUM_APB[SELW:0];

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // ICB handshake: a beat moves on a rising edge where valid and ready are both 1;
  // ready never depends on valid, and rsp_valid/rdata/err hold until rsp_ready.

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            read_q, read_d;
  logic            pwrite_q, pwrite_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]   pstrb_q, pstrb_d;
  logic [SELW-1:0] idx_q, idx_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [TOW-1:0]  cnt_q, cnt_d;

  logic [SELW-1:0] cmd_idx;
  logic            cmd_hit;
  logic            sel_ready;
  logic            sel_err;
  logic [DW-1:0]   sel_rdata;
  logic [TOW:0]    cnt_inc;
  logic            tmo_hit;

  assign cmd_idx = icb_cmd_addr[SEL_LSB +: SELW];
  assign cmd_hit = (icb_cmd_addr[AW-1:TOP] == BASE_ADDR[AW-1:TOP]) &&
                   ({1'b0, cmd_idx} < NUM_LIM);

  // Only the addressed channel is ever selected; its ready/error/data are the only ones seen.
  always_comb begin
    apb_psel  = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_APB; i++) begin
      if ((state_q == S_SETUP || state_q == S_ACCESS) && idx_q == SELW'(i)) begin
        apb_psel[i] = 1'b1;
        sel_ready   = apb_pready[i];
        sel_err     = apb_pslverr[i];
        sel_rdata   = apb_prdata[i*DW +: DW];
      end
    end
  end

  assign cnt_inc = {1'b0, cnt_q} + {{TOW{1'b0}}, 1'b1};
  assign tmo_hit = (TIMEOUT != 0) && (cnt_inc == TMO_LIM);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    read_d   = read_q;
    pwrite_d = pwrite_q;
    wdata_d  = wdata_q;
    pstrb_d  = pstrb_q;
    idx_d    = idx_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (icb_cmd_valid) begin
          addr_d   = icb_cmd_addr;
          read_d   = icb_cmd_read;
          pwrite_d = ~icb_cmd_read;
          wdata_d  = icb_cmd_wdata;
          pstrb_d  = icb_cmd_read ? '0 : icb_cmd_wmask;
          idx_d    = cmd_idx;
          if (cmd_hit) begin
            state_d = S_SETUP;
          end else begin
            state_d = S_RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = '0;
      end
      S_ACCESS: begin
        if (sel_ready) begin
          rdata_d = read_q ? sel_rdata : '0;
          err_d   = sel_err;
          state_d = S_RESP;
        end else if (tmo_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc[TOW-1:0];
        end
      end
      S_RESP: begin
        if (icb_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      read_q   <= 1'b0;
      pwrite_q <= 1'b0;
      wdata_q  <= '0;
      pstrb_q  <= '0;
      idx_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      read_q   <= read_d;
      pwrite_q <= pwrite_d;
      wdata_q  <= wdata_d;
      pstrb_q  <= pstrb_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Held low while reset is asserted even though the state register already reads IDLE.
  assign icb_cmd_ready = rst_n && (state_q == S_IDLE);
  assign icb_rsp_valid = (state_q == S_RESP);
  assign icb_rsp_rdata = rdata_q;
  assign icb_rsp_err   = err_q;
  assign apb_paddr     = addr_q;
  assign apb_pwrite    = pwrite_q;
  assign apb_pwdata    = wdata_q;
  assign apb_pstrb     = pstrb_q;
  assign apb_pprot     = 3'b000;
  assign apb_penable   = (state_q == S_ACCESS);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_icb2apb_bridge_n.sv
// Bench for icb2apb_bridge_n: directed scenarios plus random traffic against a
// transaction-level model of decode, slave wait states, timeout and error rules.
module tb_icb2apb_bridge_n;
  localparam int NUM_APB = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int SEL_LSB = 12;
  localparam int TIMEOUT = 256;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam longint WIN = longint'(1) << (SEL_LSB + 2);

  logic clk = 1'b0;
  logic rst_n;
  logic icb_cmd_valid = 1'b0;
  logic icb_cmd_ready;
  logic [AW-1:0] icb_cmd_addr = '0;
  logic icb_cmd_read = 1'b0;
  logic [DW-1:0] icb_cmd_wdata = '0;
  logic [MW-1:0] icb_cmd_wmask = '0;
  logic icb_rsp_valid;
  logic icb_rsp_ready = 1'b0;
  logic [DW-1:0] icb_rsp_rdata;
  logic icb_rsp_err;
  logic [AW-1:0] apb_paddr;
  logic apb_pwrite;
  logic [DW-1:0] apb_pwdata;
  logic [MW-1:0] apb_pstrb;
  logic [2:0] apb_pprot;
  logic apb_penable;
  logic [NUM_APB-1:0] apb_psel;
  logic [NUM_APB*DW-1:0] apb_prdata = '0;
  logic [NUM_APB-1:0] apb_pready = '0;
  logic [NUM_APB-1:0] apb_pslverr = '0;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  int waits[NUM_APB];
  logic slverr_cfg[NUM_APB];
  logic [DW-1:0] rd_cfg[NUM_APB];
  int acc_cnt[NUM_APB];

  typedef struct {
    int lat; logic [DW-1:0] rdata; logic err; int sel_cyc; int en_cyc;
    logic [NUM_APB-1:0] sel_or; int bad; int vcyc; bit tmo;
  } obs_t;

  typedef struct {
    int lat; logic [DW-1:0] rdata; logic err; int sel_cyc; int en_cyc; logic [NUM_APB-1:0] sel;
  } exp_t;

  icb2apb_bridge_n #(
    .NUM_APB(NUM_APB), .AW(AW), .DW(DW), .SEL_LSB(SEL_LSB),
    .BASE_ADDR(BASE), .TIMEOUT(TIMEOUT), .TOW(9)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .apb_paddr(apb_paddr), .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata),
    .apb_pstrb(apb_pstrb), .apb_pprot(apb_pprot), .apb_penable(apb_penable),
    .apb_psel(apb_psel), .apb_prdata(apb_prdata), .apb_pready(apb_pready),
    .apb_pslverr(apb_pslverr), .dbg_state_o(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // APB slave models: selected channel answers after waits[i] ACCESS cycles,
  // every other input bit is noise the bridge must ignore.
  always @(negedge clk) begin
    for (int i = 0; i < NUM_APB; i++) begin
      if (apb_psel[i] && apb_penable) begin
        apb_pready[i] = (acc_cnt[i] == waits[i]);
        apb_pslverr[i] = apb_pready[i] ? slverr_cfg[i] : 1'($urandom_range(0, 1));
        apb_prdata[i*DW +: DW] = apb_pready[i] ? rd_cfg[i] : $urandom;
        acc_cnt[i]++;
      end else begin
        acc_cnt[i] = 0;
        apb_pready[i] = 1'($urandom_range(0, 1));
        apb_pslverr[i] = 1'($urandom_range(0, 1));
        apb_prdata[i*DW +: DW] = $urandom;
      end
    end
  end

  // Reference model: window decode by address arithmetic, then slave behaviour.
  function automatic exp_t model(input logic [AW-1:0] addr, input logic rd);
    exp_t e;
    longint off;
    int ch;
    int w;
    off = longint'(addr) - longint'(BASE);
    e.sel = '0;
    if (off < 0 || off >= WIN || (off / (longint'(1) << SEL_LSB)) >= NUM_APB) begin
      e.lat = 1; e.rdata = '0; e.err = 1'b1; e.sel_cyc = 0; e.en_cyc = 0;
    end else begin
      ch = int'(off / (longint'(1) << SEL_LSB));
      w = waits[ch];
      e.sel[ch] = 1'b1;
      if (TIMEOUT != 0 && w >= TIMEOUT) begin
        e.en_cyc = TIMEOUT; e.lat = 2 + TIMEOUT; e.rdata = '0; e.err = 1'b1;
      end else begin
        e.en_cyc = w + 1; e.lat = 3 + w; e.rdata = rd ? rd_cfg[ch] : '0; e.err = slverr_cfg[ch];
      end
      e.sel_cyc = e.en_cyc + 1;
    end
    return e;
  endfunction

  // Driver: issues one command, observes APB/ICB activity, holds off rsp_ready for 'hold' cycles.
  task automatic run_xfer(input logic [AW-1:0] addr, input logic rd, input logic [DW-1:0] wd,
                          input logic [MW-1:0] wm, input int hold, output obs_t o);
    int k;
    logic [DW-1:0] r0;
    logic e0;
    o = '{default: 0};
    k = 0;
    while (!icb_cmd_ready && k < 50) begin @(negedge clk); k++; end
    if (!icb_cmd_ready) begin o.tmo = 1'b1; return; end
    icb_cmd_valid = 1'b1; icb_cmd_addr = addr; icb_cmd_read = rd;
    icb_cmd_wdata = wd; icb_cmd_wmask = wm;
    @(negedge clk);
    icb_cmd_valid = 1'b0; icb_cmd_addr = $urandom; icb_cmd_read = 1'($urandom_range(0, 1));
    icb_cmd_wdata = $urandom; icb_cmd_wmask = 4'($urandom);
    o.lat = 1;
    while (!icb_rsp_valid && o.lat < 2000) begin
      if (icb_cmd_ready) o.bad++;
      if (apb_psel != 0) begin
        o.sel_cyc++;
        o.sel_or |= apb_psel;
        if (!$onehot(apb_psel)) o.bad++;
        if (o.sel_cyc == 1 && apb_penable) o.bad++;
        if (apb_paddr !== addr || apb_pwrite !== ~rd || apb_pwdata !== wd ||
            apb_pstrb !== (rd ? 4'b0000 : wm)) o.bad++;
      end else if (apb_penable) o.bad++;
      if (apb_penable) o.en_cyc++;
      @(negedge clk);
      o.lat++;
    end
    if (!icb_rsp_valid) begin o.tmo = 1'b1; return; end
    r0 = icb_rsp_rdata; e0 = icb_rsp_err;
    o.rdata = r0; o.err = e0;
    o.vcyc = 1;
    if (icb_cmd_ready || apb_psel != 0 || apb_penable) o.bad++;
    while (o.vcyc <= hold) begin
      @(negedge clk);
      o.vcyc++;
      if (!icb_rsp_valid || icb_rsp_rdata !== r0 || icb_rsp_err !== e0 ||
          icb_cmd_ready || apb_psel != 0 || apb_penable) o.bad++;
    end
    icb_rsp_ready = 1'b1;
    @(negedge clk);
    icb_rsp_ready = 1'b0;
    if (icb_rsp_valid || !icb_cmd_ready) o.bad++;
  endtask

  logic [1:0] reset_state;

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_state = dbg_state;
    n_checks++; if (icb_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 0", icb_cmd_ready); end
    n_checks++; if (icb_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", icb_rsp_valid); end
    n_checks++; if (icb_rsp_rdata !== '0 || icb_rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp: got %h/%b want 0/0", icb_rsp_rdata, icb_rsp_err); end
    n_checks++; if (apb_psel !== '0 || apb_penable !== 1'b0) begin n_fail++; $display("FAIL rst_psel: got %b/%b want 0/0", apb_psel, apb_penable); end
    n_checks++; if (apb_paddr !== '0 || apb_pwdata !== '0 || apb_pstrb !== '0 || apb_pwrite !== 1'b0) begin n_fail++; $display("FAIL rst_apb: got %h %h %b %b want zeros", apb_paddr, apb_pwdata, apb_pstrb, apb_pwrite); end
    n_checks++; if (apb_pprot !== 3'b000) begin n_fail++; $display("FAIL rst_pprot: got %b want 000", apb_pprot); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (icb_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", icb_cmd_ready); end
    n_checks++; if (dbg_state !== reset_state) begin n_fail++; $display("FAIL rst_idle_state: got %b want %b", dbg_state, reset_state); end
  endtask

  task automatic test_write_hit();
    obs_t o; exp_t e;
    waits[2] = 0; slverr_cfg[2] = 1'b0;
    e = model(32'h1000_2004, 1'b0);
    run_xfer(32'h1000_2004, 1'b0, 32'hA5A5_0001, 4'b0011, 0, o);
    n_checks++; if (o.tmo || o.bad != 0) begin n_fail++; $display("FAIL wr_protocol: tmo=%b bad=%0d want 0/0", o.tmo, o.bad); end
    n_checks++; if (o.lat != e.lat) begin n_fail++; $display("FAIL wr_latency: got %0d want %0d", o.lat, e.lat); end
    n_checks++; if (o.sel_or !== e.sel || o.sel_cyc != e.sel_cyc || o.en_cyc != e.en_cyc) begin n_fail++; $display("FAIL wr_psel: got %b/%0d/%0d want %b/%0d/%0d", o.sel_or, o.sel_cyc, o.en_cyc, e.sel, e.sel_cyc, e.en_cyc); end
    n_checks++; if (o.err !== e.err || o.rdata !== e.rdata) begin n_fail++; $display("FAIL wr_rsp: got %b/%h want %b/%h", o.err, o.rdata, e.err, e.rdata); end
  endtask

  task automatic test_read_wait();
    obs_t o; exp_t e;
    waits[3] = 3; slverr_cfg[3] = 1'b0; rd_cfg[3] = 32'hDEAD_BEEF;
    e = model(32'h1000_3000, 1'b1);
    run_xfer(32'h1000_3000, 1'b1, 32'h0, 4'hF, 0, o);
    n_checks++; if (o.tmo || o.bad != 0) begin n_fail++; $display("FAIL rdw_protocol: tmo=%b bad=%0d want 0/0", o.tmo, o.bad); end
    n_checks++; if (o.lat != e.lat) begin n_fail++; $display("FAIL rdw_latency: got %0d want %0d", o.lat, e.lat); end
    n_checks++; if (o.en_cyc != e.en_cyc || o.sel_or !== e.sel) begin n_fail++; $display("FAIL rdw_penable: got %0d/%b want %0d/%b", o.en_cyc, o.sel_or, e.en_cyc, e.sel); end
    n_checks++; if (o.rdata !== e.rdata || o.err !== e.err) begin n_fail++; $display("FAIL rdw_rdata: got %h/%b want %h/%b", o.rdata, o.err, e.rdata, e.err); end
  endtask

  task automatic test_decode_miss();
    logic [AW-1:0] addrs[4];
    obs_t o; exp_t e;
    addrs[0] = 32'h2000_0000; addrs[1] = 32'h1000_4000;
    addrs[2] = 32'h0FFF_FFFC; addrs[3] = 32'h9000_3000;
    foreach (addrs[j]) begin
      e = model(addrs[j], 1'b1);
      run_xfer(addrs[j], 1'b1, 32'h0, 4'h0, j, o);
      n_checks++; if (o.tmo || o.bad != 0 || o.vcyc != j + 1) begin n_fail++; $display("FAIL miss_protocol[%0d]: tmo=%b bad=%0d vcyc=%0d want 0/0/%0d", j, o.tmo, o.bad, o.vcyc, j + 1); end
      n_checks++; if (o.lat != e.lat || o.sel_cyc != 0) begin n_fail++; $display("FAIL miss_latency[%0d]: got %0d sel=%0d want %0d sel=0", j, o.lat, o.sel_cyc, e.lat); end
      n_checks++; if (o.err !== e.err || o.rdata !== e.rdata) begin n_fail++; $display("FAIL miss_rsp[%0d]: got %b/%h want %b/%h", j, o.err, o.rdata, e.err, e.rdata); end
    end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    waits[1] = 1_000_000; slverr_cfg[1] = 1'b0; rd_cfg[1] = 32'h1234_5678;
    e = model(32'h1000_1008, 1'b1);
    run_xfer(32'h1000_1008, 1'b1, 32'h0, 4'h0, 1, o);
    n_checks++; if (o.tmo || o.bad != 0) begin n_fail++; $display("FAIL tmo_protocol: tmo=%b bad=%0d want 0/0", o.tmo, o.bad); end
    n_checks++; if (o.lat != e.lat || o.en_cyc != e.en_cyc) begin n_fail++; $display("FAIL tmo_cycles: got lat=%0d en=%0d want lat=%0d en=%0d", o.lat, o.en_cyc, e.lat, e.en_cyc); end
    n_checks++; if (o.err !== e.err || o.rdata !== e.rdata) begin n_fail++; $display("FAIL tmo_rsp: got %b/%h want %b/%h", o.err, o.rdata, e.err, e.rdata); end
    waits[1] = 0;
  endtask

  task automatic test_slverr_backpressure();
    obs_t o; exp_t e;
    waits[0] = 0; slverr_cfg[0] = 1'b1;
    e = model(32'h1000_0010, 1'b0);
    run_xfer(32'h1000_0010, 1'b0, 32'hCAFE_F00D, 4'b1100, 5, o);
    n_checks++; if (o.tmo || o.bad != 0) begin n_fail++; $display("FAIL bp_stable: tmo=%b bad=%0d want 0/0", o.tmo, o.bad); end
    n_checks++; if (o.vcyc != 6) begin n_fail++; $display("FAIL bp_valid_cycles: got %0d want 6", o.vcyc); end
    n_checks++; if (o.err !== e.err || o.lat != e.lat) begin n_fail++; $display("FAIL bp_err: got %b lat=%0d want %b lat=%0d", o.err, o.lat, e.err, e.lat); end
    slverr_cfg[0] = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    obs_t o; exp_t e;
    int k;
    waits[2] = 10;
    while (!icb_cmd_ready) @(negedge clk);
    icb_cmd_valid = 1'b1; icb_cmd_addr = 32'h1000_2000; icb_cmd_read = 1'b1;
    @(negedge clk);
    icb_cmd_valid = 1'b0;
    k = 0;
    while (!apb_penable && k < 20) begin @(negedge clk); k++; end
    n_checks++; if (apb_penable !== 1'b1) begin n_fail++; $display("FAIL mid_reach_access: got penable=%b want 1", apb_penable); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (apb_psel !== '0 || apb_penable !== 1'b0) begin n_fail++; $display("FAIL mid_rst_apb: got %b/%b want 0/0", apb_psel, apb_penable); end
    n_checks++; if (icb_rsp_valid !== 1'b0 || icb_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_icb: got valid=%b ready=%b want 0/0", icb_rsp_valid, icb_cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (icb_cmd_ready !== 1'b1 || icb_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_release: got ready=%b valid=%b want 1/0", icb_cmd_ready, icb_rsp_valid); end
    waits[2] = 1; slverr_cfg[2] = 1'b0;
    e = model(32'h1000_2040, 1'b0);
    run_xfer(32'h1000_2040, 1'b0, 32'h0BAD_F00D, 4'b1111, 0, o);
    n_checks++; if (o.tmo || o.bad != 0 || o.lat != e.lat || o.err !== e.err || o.sel_or !== e.sel) begin n_fail++; $display("FAIL mid_after: tmo=%b bad=%0d lat=%0d err=%b sel=%b want lat=%0d err=%b sel=%b", o.tmo, o.bad, o.lat, o.err, o.sel_or, e.lat, e.err, e.sel); end
  endtask

  task automatic test_back_to_back_random();
    obs_t o; exp_t e;
    logic [AW-1:0] addr;
    logic rd;
    int hold;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NUM_APB; i++) begin
        waits[i] = $urandom_range(0, 4);
        slverr_cfg[i] = ($urandom_range(0, 3) == 0);
        rd_cfg[i] = $urandom;
      end
      case ($urandom_range(0, 3))
        0, 1: addr = BASE + ($urandom_range(0, 3) << SEL_LSB) + ($urandom_range(0, 1023) << 2);
        2: addr = $urandom;
        default: case ($urandom_range(0, 3))
          0: addr = BASE - 4;
          1: addr = BASE + 32'(WIN);
          2: addr = BASE + 32'(WIN) - 4;
          default: addr = BASE;
        endcase
      endcase
      rd = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      e = model(addr, rd);
      run_xfer(addr, rd, $urandom, 4'($urandom), hold, o);
      n_checks++; if (o.tmo || o.bad != 0 || o.vcyc != hold + 1) begin n_fail++; $display("FAIL rnd_protocol[%0d]: addr=%h tmo=%b bad=%0d vcyc=%0d want vcyc=%0d", t, addr, o.tmo, o.bad, o.vcyc, hold + 1); end
      n_checks++; if (o.lat != e.lat || o.sel_or !== e.sel || o.en_cyc != e.en_cyc || o.sel_cyc != e.sel_cyc) begin n_fail++; $display("FAIL rnd_timing[%0d]: addr=%h got lat=%0d sel=%b en=%0d want lat=%0d sel=%b en=%0d", t, addr, o.lat, o.sel_or, o.en_cyc, e.lat, e.sel, e.en_cyc); end
      n_checks++; if (o.rdata !== e.rdata || o.err !== e.err) begin n_fail++; $display("FAIL rnd_rsp[%0d]: addr=%h got %h/%b want %h/%b", t, addr, o.rdata, o.err, e.rdata, e.err); end
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_APB; i++) begin
      waits[i] = 0; slverr_cfg[i] = 1'b0; rd_cfg[i] = $urandom; acc_cnt[i] = 0;
    end
    test_reset();
    test_write_hit();
    test_read_wait();
    test_decode_miss();
    test_timeout();
    test_slverr_backpressure();
    test_reset_mid_access();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
